// File: rtl/send_scheduler_pkg.sv
// Shared definitions for the send scheduler: FSM states, source ids, defaults.
package send_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic SRC_STAT = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/send_scheduler_if.sv
// Byte-serial sender handshake: scheduler drives transmit/txByte, sender reports busy.
interface send_scheduler_if;

  logic       transmit;
  logic [7:0] txByte;
  logic       isTransmitting;

  modport master (
    output transmit,
    output txByte,
    input  isTransmitting
  );

  modport slave (
    input  transmit,
    input  txByte,
    output isTransmitting
  );

endinterface

// File: rtl/send_scheduler_byte_fifo.sv
// Byte-wide synchronous FIFO with a combinationally visible head entry.
module byte_fifo
  import send_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               push_data,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the level.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/send_scheduler.sv
// Packs TRNG bits into bytes, queues them, and arbitrates data vs status bytes
// onto the byte-serial sender handshake.
module send_scheduler
  import send_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    enable,
  input  logic                    bitIn,
  input  logic                    bitValid,
  input  logic                    statReq,
  input  logic [7:0]              statByte,
  output logic                    statAck,
  send_scheduler_if.master        bus,
  output logic                    overflow,
  input  logic                    clearOvf,
  output logic [$clog2(DEPTH):0]  fifoLevel,
  output logic [CNT_W-1:0]        bytesSent
);

  logic [2:0]       bit_cnt;
  logic [6:0]       shift_reg;
  logic             byte_done;
  logic [7:0]       packed_byte;

  logic             pop;
  logic [7:0]       head;
  logic             full;
  logic             empty;

  state_t           state;
  state_t           next_state;
  logic             prio;
  logic             next_prio;
  logic             winner;
  logic             stat_ack;
  logic [7:0]       tx_byte;
  logic [CNT_W-1:0] sent_cnt;
  logic             ovf_flag;

  assign byte_done   = enable && bitValid && (bit_cnt == 3'd7);
  assign packed_byte = {shift_reg, bitIn};

  // MSB-first bit packer; dropping enable discards any partial byte.
  always_ff @(posedge clk) begin
    if (!rstN || !enable) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (bitValid) begin
      if (bit_cnt == 3'd7) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else begin
        bit_cnt   <= bit_cnt + 3'd1;
        shift_reg <= {shift_reg[5:0], bitIn};
      end
    end
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstN      (rstN),
    .push      (byte_done),
    .pop       (pop),
    .push_data (packed_byte),
    .head      (head),
    .level     (fifoLevel),
    .full      (full),
    .empty     (empty)
  );

  // Next-state, round-robin source selection and selection-cycle strobes.
  always_comb begin
    next_state = state;
    next_prio  = prio;
    winner     = SRC_STAT;
    pop        = 1'b0;
    stat_ack   = 1'b0;
    if (rstN) begin
      unique case (state)
        IDLE: begin
          if (!bus.isTransmitting && (statReq || !empty)) begin
            if (statReq && !empty) begin
              winner    = prio;
              next_prio = ~prio;
            end else if (statReq) begin
              winner = SRC_STAT;
            end else begin
              winner = SRC_DATA;
            end
            next_state = ISSUE;
            if (winner == SRC_STAT) begin
              stat_ack = 1'b1;
            end else begin
              pop = 1'b1;
            end
          end
        end
        ISSUE:     next_state = WAIT_BUSY;
        WAIT_BUSY: if (bus.isTransmitting) next_state = WAIT_DONE;
        WAIT_DONE: if (!bus.isTransmitting) next_state = IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  // FSM state and arbitration pointer; pointer starts favouring status.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= IDLE;
      prio  <= SRC_STAT;
    end else begin
      state <= next_state;
      prio  <= next_prio;
    end
  end

  // Output byte register, loaded from the winning source in the selection cycle.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      tx_byte <= '0;
    end else if (stat_ack) begin
      tx_byte <= statByte;
    end else if (pop) begin
      tx_byte <= head;
    end
  end

  // Sent-byte counter, bumped once per transmit pulse and free to wrap.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      sent_cnt <= '0;
    end else if (state == ISSUE) begin
      sent_cnt <= sent_cnt + 1'b1;
    end
  end

  // Sticky overflow: a completed byte that the full FIFO could not take wins over clear.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      ovf_flag <= 1'b0;
    end else if (byte_done && full && !pop) begin
      ovf_flag <= 1'b1;
    end else if (clearOvf) begin
      ovf_flag <= 1'b0;
    end
  end

  assign bus.transmit = (state == ISSUE);
  assign bus.txByte   = tx_byte;
  assign statAck      = stat_ack;
  assign bytesSent    = sent_cnt;
  assign overflow     = ovf_flag;

endmodule

// File: tb/tb_send_scheduler.sv
// Self-checking bench for send_scheduler with a behavioural sender, requester and byte model.
module tb_send_scheduler;

  localparam int DEPTH = 16;
  localparam int CNT_W = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rstN;
  logic             enable;
  logic             bitIn;
  logic             bitValid;
  logic             statReq;
  logic [7:0]       statByte;
  logic             statAck;
  logic             overflow;
  logic             clearOvf;
  logic [LW-1:0]    fifoLevel;
  logic [CNT_W-1:0] bytesSent;

  send_scheduler_if sif ();

  send_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .enable    (enable),
    .bitIn     (bitIn),
    .bitValid  (bitValid),
    .statReq   (statReq),
    .statByte  (statByte),
    .statAck   (statAck),
    .bus       (sif),
    .overflow  (overflow),
    .clearOvf  (clearOvf),
    .fifoLevel (fifoLevel),
    .bytesSent (bytesSent)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int ackCount   = 0;
  int busyLen    = 1;
  int busyCnt    = 0;
  logic forceBusy = 1'b0;
  logic reqStart  = 1'b0;
  logic reqCancel = 1'b0;

  bit         bitQ [$];
  logic [7:0] expQ [$];
  logic [7:0] obsQ [$];
  int         obsT [$];

  // Cycle counter used to timestamp transmit pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Sender model: busy for busyLen cycles after each transmit, or held busy on demand.
  always @(posedge clk) begin
    if (forceBusy) begin
      sif.isTransmitting <= 1'b1;
      busyCnt <= 0;
    end else if (sif.transmit === 1'b1) begin
      sif.isTransmitting <= 1'b1;
      busyCnt <= busyLen;
    end else if (busyCnt > 1) begin
      busyCnt <= busyCnt - 1;
    end else begin
      busyCnt <= 0;
      sif.isTransmitting <= 1'b0;
    end
  end

  // Status requester: raises statReq on request, drops it on ack or cancel.
  always @(posedge clk) begin
    if (!rstN) statReq <= 1'b0;
    else if (reqStart) statReq <= 1'b1;
    else if (reqCancel || statAck) statReq <= 1'b0;
  end

  // Monitor recording every byte handed to the sender and every status ack.
  always @(negedge clk) begin
    if (sif.transmit === 1'b1) begin
      obsQ.push_back(sif.txByte);
      obsT.push_back(cyc);
    end
    if (statAck === 1'b1) ackCount <= ackCount + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of packer inputs and update the byte model from the bit stream.
  task automatic applyStimulus(logic en, logic valid, logic b);
    int v;
    enable   = en;
    bitValid = valid;
    bitIn    = b;
    if (!en) begin
      bitQ.delete();
    end else if (valid) begin
      bitQ.push_back(b);
      if (bitQ.size() == 8) begin
        v = 0;
        foreach (bitQ[i]) v = v * 2 + int'(bitQ[i]);
        expQ.push_back(8'(v));
        bitQ.delete();
      end
    end
    step();
  endtask

  task automatic feedByte(logic [7:0] v);
    for (int i = 7; i >= 0; i--) applyStimulus(1'b1, 1'b1, v[i]);
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    forceBusy = 1'b0;
    reqStart = 1'b0;
    reqCancel = 1'b0;
    clearOvf = 1'b0;
    enable = 1'b0;
    bitValid = 1'b0;
    bitIn = 1'b0;
    step();
    step();
    rstN = 1'b1;
    bitQ.delete();
    expQ.delete();
  endtask

  task automatic waitDrain(int limit);
    int n = 0;
    while ((fifoLevel != '0 || sif.isTransmitting || statReq) && n < limit) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    repeat (15) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("drainLevel", 32'(fifoLevel), 32'd0);
  endtask

  task automatic compareSent(string tag, int base);
    int n;
    checkOutput({tag, "Count"}, 32'(obsQ.size() - base), 32'(expQ.size()));
    n = (obsQ.size() - base < expQ.size()) ? obsQ.size() - base : expQ.size();
    for (int i = 0; i < n; i++) checkOutput(tag, 32'(obsQ[base + i]), 32'(expQ[i]));
  endtask

  initial begin
    int base;
    int ackBase;
    int n;
    logic [7:0] v;

    statByte = 8'h00;

    // Reset state
    applyReset();
    rstN = 1'b0;
    step();
    checkOutput("rstTransmit", 32'(sif.transmit), 32'd0);
    checkOutput("rstStatAck", 32'(statAck), 32'd0);
    checkOutput("rstTxByte", 32'(sif.txByte), 32'd0);
    checkOutput("rstOverflow", 32'(overflow), 32'd0);
    checkOutput("rstLevel", 32'(fifoLevel), 32'd0);
    checkOutput("rstSent", bytesSent, 32'd0);
    rstN = 1'b1;

    // Single byte, fast sender
    $display("[TB] single byte B2");
    busyLen = 1;
    base = obsQ.size();
    applyStimulus(1, 1, 1); applyStimulus(1, 1, 0); applyStimulus(1, 1, 1); applyStimulus(1, 1, 1);
    applyStimulus(1, 1, 0); applyStimulus(1, 1, 0); applyStimulus(1, 1, 1); applyStimulus(1, 1, 0);
    checkOutput("t1Level", 32'(fifoLevel), 32'd1);
    applyStimulus(0, 0, 0);
    checkOutput("t1Transmit", 32'(sif.transmit), 32'd1);
    checkOutput("t1TxByte", 32'(sif.txByte), 32'hB2);
    applyStimulus(0, 0, 0);
    checkOutput("t1Sent", bytesSent, 32'd1);
    checkOutput("t1Pulse", 32'(sif.transmit), 32'd0);
    waitDrain(100);
    compareSent("t1Data", base);

    // Three bytes with a slow sender
    $display("[TB] three bytes, busy 9");
    applyReset();
    busyLen = 9;
    base = obsQ.size();
    for (int k = 0; k < 3; k++) feedByte(8'($urandom));
    waitDrain(300);
    compareSent("t2Data", base);
    checkOutput("t2Sent", bytesSent, 32'd3);
    if (obsT.size() >= base + 3) begin
      for (int i = 1; i < 3; i++)
        checkOutput("t2Spacing", 32'(obsT[base + i] - obsT[base + i - 1] >= 12), 32'd1);
    end

    // Status and data arbitration
    $display("[TB] arbitration");
    applyReset();
    busyLen = 2;
    forceBusy = 1'b1;
    step();
    feedByte(8'h11);
    feedByte(8'h22);
    applyStimulus(0, 0, 0);
    statByte = 8'hA5;
    reqStart = 1'b1;
    step();
    reqStart = 1'b0;
    checkOutput("t3Level", 32'(fifoLevel), 32'd2);
    base = obsQ.size();
    ackBase = ackCount;
    expQ.delete();
    expQ.push_back(8'hA5);
    expQ.push_back(8'h11);
    expQ.push_back(8'h22);
    forceBusy = 1'b0;
    waitDrain(200);
    compareSent("t3Order", base);
    checkOutput("t3Acks", 32'(ackCount - ackBase), 32'd1);

    // Status request withdrawn before ack
    base = obsQ.size();
    ackBase = ackCount;
    forceBusy = 1'b1;
    step();
    reqStart = 1'b1;
    step();
    reqStart = 1'b0;
    reqCancel = 1'b1;
    step();
    reqCancel = 1'b0;
    forceBusy = 1'b0;
    repeat (20) step();
    checkOutput("cancelSent", 32'(obsQ.size() - base), 32'd0);
    checkOutput("cancelAck", 32'(ackCount - ackBase), 32'd0);

    // Overflow with a stalled sender
    $display("[TB] overflow");
    applyReset();
    forceBusy = 1'b1;
    step();
    base = obsQ.size();
    for (int k = 0; k < DEPTH; k++) feedByte(8'($urandom));
    checkOutput("t4LevelFull", 32'(fifoLevel), 32'(DEPTH));
    checkOutput("t4NoOvf", 32'(overflow), 32'd0);
    feedByte(8'($urandom));
    void'(expQ.pop_back());
    checkOutput("t4Level", 32'(fifoLevel), 32'(DEPTH));
    checkOutput("t4Ovf", 32'(overflow), 32'd1);
    clearOvf = 1'b1;
    applyStimulus(0, 0, 0);
    clearOvf = 1'b0;
    checkOutput("t4Clear", 32'(overflow), 32'd0);
    busyLen = 1;
    forceBusy = 1'b0;
    waitDrain(1000);
    compareSent("t4Data", base);

    // Partial byte discarded by enable drop
    $display("[TB] partial discard");
    applyReset();
    busyLen = 1;
    base = obsQ.size();
    for (int k = 0; k < 5; k++) applyStimulus(1, 1, 1'($urandom));
    applyStimulus(0, 0, 0);
    v = 8'($urandom);
    feedByte(v);
    waitDrain(100);
    compareSent("t5Data", base);
    if (obsQ.size() > base) checkOutput("t5Byte", 32'(obsQ[base]), 32'(v));

    // Reset during WAIT_DONE with bytes queued
    $display("[TB] reset mid-transfer");
    applyReset();
    busyLen = 9;
    feedByte(8'($urandom));
    n = 0;
    while (sif.transmit !== 1'b1 && n < 20) begin
      applyStimulus(0, 0, 0);
      n++;
    end
    checkOutput("t6Issue", 32'(sif.transmit), 32'd1);
    forceBusy = 1'b1;
    step();
    step();
    for (int k = 0; k < 3; k++) feedByte(8'($urandom));
    checkOutput("t6Queued", 32'(fifoLevel), 32'd3);
    rstN = 1'b0;
    step();
    checkOutput("t6Transmit", 32'(sif.transmit), 32'd0);
    checkOutput("t6Level", 32'(fifoLevel), 32'd0);
    checkOutput("t6Sent", bytesSent, 32'd0);
    rstN = 1'b1;
    forceBusy = 1'b0;
    base = obsQ.size();
    repeat (30) applyStimulus(0, 0, 0);
    checkOutput("t6Quiet", 32'(obsQ.size() - base), 32'd0);

    // Randomised bit stream against the byte model
    $display("[TB] random stream");
    applyReset();
    busyLen = $urandom_range(1, 4);
    base = obsQ.size();
    for (int k = 0; k < 600; k++) begin
      if (k % 100 == 0) busyLen = $urandom_range(1, 4);
      applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0, 1'($urandom));
    end
    waitDrain(200);
    compareSent("rndData", base);
    checkOutput("rndOvf", 32'(overflow), 32'd0);
    checkOutput("rndSent", bytesSent, 32'(expQ.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
